ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xFF (reset). It runs the open-drain request-to-send sequence, shifts data out on device-generated clock edges, checks the device ACK, and reports completion or error. It sits beside the scancode receiver on the same PS2Clk/PS2Data pins; top level ties each *_oe output to an open-drain pad (oe=1 drives 0, oe=0 releases).

---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_host_tx_if.sv | 20 ++
 rtl/ps2_line_sync.sv | 72 +++++++
 rtl/ps2_host_tx.sv | 227 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, frame geometry,
// common command bytes and the frame-building helpers.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        RTS       = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_state_e;

    localparam int FRAME_BITS = 10;
    localparam int ACK_FALL   = 11;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~(^d);
    endfunction

    // Start bit sits in bit 0 so the line value is always the register LSB.
    function automatic logic [FRAME_BITS:0] build_frame(input logic [7:0] d);
        return {1'b1, odd_parity(d), d, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a controller (master) and the PS/2 host
// transmitter (slave).
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, done, err
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, done, err
    );
endinterface

// File: rtl/ps2_line_sync.sv
// Synchroniser for the PS/2 clock and data pads plus a registered falling-edge
// pulse on the clock line. PS2_TX_GLITCH_FILTER_EN adds an 8-sample clock filter.
module ps2_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ps2clk_i,
    input  logic ps2data_i,
    output logic clk_o,
    output logic data_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_lvl_s;
    logic                   prev_q;
    logic                   fall_q;

    // Pad synchroniser chains; idle lines are high so reset to ones.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2clk_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2data_i};
        end
    end

`ifdef PS2_TX_GLITCH_FILTER_EN
    logic [2:0] flt_cnt_q;
    logic       flt_q;

    // Filtered level flips only after 8 consecutive differing samples.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flt_q     <= 1'b1;
            flt_cnt_q <= 3'd0;
        end else if (clk_sync_q[SYNC_STAGES-1] != flt_q) begin
            if (flt_cnt_q == 3'd7) begin
                flt_q     <= clk_sync_q[SYNC_STAGES-1];
                flt_cnt_q <= 3'd0;
            end else begin
                flt_cnt_q <= flt_cnt_q + 3'd1;
            end
        end else begin
            flt_cnt_q <= 3'd0;
        end
    end

    assign clk_lvl_s = flt_q;
`else
    assign clk_lvl_s = clk_sync_q[SYNC_STAGES-1];
`endif

    // Falling-edge detect, registered one cycle after the level change.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            prev_q <= clk_lvl_s;
            fall_q <= prev_q & ~clk_lvl_s;
        end
    end

    assign clk_o  = clk_lvl_s;
    assign data_o = data_sync_q[SYNC_STAGES-1];
    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, device-clocked
// shift-out, ACK check. Build option PS2_TX_GLITCH_FILTER_EN filters the pad clock.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic         CLK,
    input  logic         RST,
    ps2_host_tx_if.slave tx,
    input  logic         PS2Clk,
    input  logic         PS2Data,
    output logic         ps2clk_oe,
    output logic         ps2data_oe
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_ONE  = INH_W'(1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [3:0]       LAST_DATA_FALL = 4'(FRAME_BITS - 1);

    logic clk_s, data_s, fall_s;

    ps2_state_e              state_q, state_d;
    logic [INH_W-1:0]        inh_cnt_q, inh_cnt_d;
    logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS:0]     shift_q, shift_d;
    logic                    nack_q, nack_d;
    logic                    clk_oe_q, clk_oe_d;
    logic                    data_oe_q, data_oe_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;
    logic                    ready_q, ready_d;
    logic                    accept_s, finish_s, timeout_s;

    ps2_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i    (CLK),
        .rst_i    (RST),
        .ps2clk_i (PS2Clk),
        .ps2data_i(PS2Data),
        .clk_o    (clk_s),
        .data_o   (data_s),
        .fall_o   (fall_s)
    );

    // State, counters, frame and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            inh_cnt_q <= '0;
            tmo_cnt_q <= '0;
            bit_cnt_q <= 4'd0;
            shift_q   <= '1;
            nack_q    <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            nack_q    <= nack_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

    // Next-state logic; the timeout check is ahead of the fall so it wins a tie.
    always_comb begin
        state_d   = state_q;
        accept_s  = 1'b0;
        finish_s  = 1'b0;
        timeout_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx.tx_valid && ready_q) begin
                    accept_s = 1'b1;
                    state_d  = INHIBIT;
                end else begin
                    state_d = IDLE;
                end
            end
            INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    state_d = RTS;
                end else begin
                    state_d = INHIBIT;
                end
            end
            RTS: begin
                state_d = SEND;
            end
            SEND: begin
                if (tmo_cnt_q == TMO_LAST) begin
                    timeout_s = 1'b1;
                    state_d   = IDLE;
                end else if (fall_s && (bit_cnt_q == LAST_DATA_FALL)) begin
                    state_d = ACK;
                end else begin
                    state_d = SEND;
                end
            end
            ACK: begin
                if (tmo_cnt_q == TMO_LAST) begin
                    timeout_s = 1'b1;
                    state_d   = IDLE;
                end else if (fall_s) begin
                    state_d = WAIT_IDLE;
                end else begin
                    state_d = ACK;
                end
            end
            WAIT_IDLE: begin
                if (tmo_cnt_q == TMO_LAST) begin
                    timeout_s = 1'b1;
                    state_d   = IDLE;
                end else if (clk_s && data_s) begin
                    finish_s = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d = WAIT_IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Counters, shift register and ACK sample.
    always_comb begin
        inh_cnt_d = '0;
        tmo_cnt_d = '0;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        nack_d    = nack_q;

        if (state_q == INHIBIT) begin
            inh_cnt_d = inh_cnt_q + INH_ONE;
        end else begin
            inh_cnt_d = '0;
        end

        if ((state_q == SEND) || (state_q == ACK) || (state_q == WAIT_IDLE)) begin
            tmo_cnt_d = tmo_cnt_q + TMO_ONE;
        end else begin
            tmo_cnt_d = '0;
        end

        if (state_q == IDLE) begin
            bit_cnt_d = 4'd0;
        end else if (((state_q == SEND) || (state_q == ACK)) && fall_s && (bit_cnt_q != 4'hF)) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
        end else begin
            bit_cnt_d = bit_cnt_q;
        end

        if (accept_s) begin
            shift_d = build_frame(tx.tx_data);
        end else if ((state_q == SEND) && fall_s) begin
            shift_d = {1'b1, shift_q[FRAME_BITS:1]};
        end else begin
            shift_d = shift_q;
        end

        if (accept_s) begin
            nack_d = 1'b0;
        end else if ((state_q == ACK) && fall_s && !timeout_s) begin
            nack_d = data_s;
        end else begin
            nack_d = nack_q;
        end
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        case (state_d)
            INHIBIT: begin
                clk_oe_d  = 1'b1;
                data_oe_d = 1'b0;
            end
            RTS: begin
                clk_oe_d  = 1'b1;
                data_oe_d = ~shift_d[0];
            end
            SEND: begin
                clk_oe_d  = 1'b0;
                data_oe_d = ~shift_d[0];
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
            end
        endcase
        done_d  = finish_s | timeout_s;
        err_d   = timeout_s | (finish_s & nack_q);
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE) && !done_d;
    end

    assign ps2clk_oe   = clk_oe_q;
    assign ps2data_oe  = data_oe_q;
    assign tx.tx_ready = ready_q;
    assign tx.busy     = busy_q;
    assign tx.done     = done_q;
    assign tx.err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a bus-level keyboard model clocks the frame,
// and a monitor checks every done pulse against the queued expectation.
module tb_ps2_host_tx;
    localparam int INH = 20;
    localparam int TMO = 800;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
        logic       chk_frame;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic ps2clk_oe, ps2data_oe;
    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    logic PS2Clk, PS2Data;
    logic [10:0] dev_frame = '0;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    ps2_host_tx_if tx_if();

    assign PS2Clk  = ~(ps2clk_oe | dev_clk_low);
    assign PS2Data = ~(ps2data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .SYNC_STAGES   (2)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .tx        (tx_if),
        .PS2Clk    (PS2Clk),
        .PS2Data   (PS2Data),
        .ps2clk_oe (ps2clk_oe),
        .ps2data_oe(ps2data_oe)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame as it should appear on the wire: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] wire_frame(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send_byte(input logic [7:0] d);
        int n = 0;
        while (tx_if.tx_ready !== 1'b1 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 2000) check("ready_wait", 32'(n), 32'(0));
        tx_if.tx_data  = d;
        tx_if.tx_valid = 1'b1;
        @(negedge CLK);
        tx_if.tx_valid = 1'b0;
    endtask

    // Keyboard model: waits for the request, clocks the frame, then ACKs or not.
    task automatic run_device(input bit ack, input int abort_after);
        int n = 0;
        int hp;
        hp = int'($urandom_range(12, 6));
        while (!(ps2clk_oe === 1'b0 && ps2data_oe === 1'b1) && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 5000) begin
            check("rts_wait", 32'(n), 32'(0));
            return;
        end
        repeat (hp) @(negedge CLK);
        dev_frame[0] = PS2Data;
        for (int k = 1; k <= 10; k++) begin
            dev_clk_low = 1'b1;
            repeat (hp) @(negedge CLK);
            dev_clk_low = 1'b0;
            if (abort_after == k) return;
            dev_frame[k] = PS2Data;
            repeat (hp) @(negedge CLK);
        end
        dev_data_low = ack;
        repeat (2) @(negedge CLK);
        dev_clk_low = 1'b1;
        repeat (hp) @(negedge CLK);
        dev_clk_low = 1'b0;
        repeat (hp) @(negedge CLK);
        dev_data_low = 1'b0;
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (tx_if.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("err", 32'(tx_if.err), 32'(e.err));
                    check("lines_released", {30'd0, ps2clk_oe, ps2data_oe}, 32'(0));
                    if (e.chk_frame) check("frame", 32'(dev_frame), 32'(wire_frame(e.data)));
                end
                check("ready_low_at_done", 32'(tx_if.tx_ready), 32'(0));
                @(negedge CLK);
                check("ready_after_done", 32'(tx_if.tx_ready), 32'(1));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : stim
        logic [7:0] d;
        bit         ack;
        int         n;
        int         n_inh;
        int         n_rts;
        tx_if.tx_data  = 8'h00;
        tx_if.tx_valid = 1'b0;

        repeat (3) @(negedge CLK);
        check("rst_ready", 32'(tx_if.tx_ready), 32'(1));
        check("rst_busy",  32'(tx_if.busy), 32'(0));
        check("rst_done",  32'(tx_if.done), 32'(0));
        check("rst_err",   32'(tx_if.err), 32'(0));
        check("rst_oe",    {30'd0, ps2clk_oe, ps2data_oe}, 32'(0));
        RST = 1'b0;
        @(negedge CLK);

        // Set-LED command with ACK.
        exp_q.push_back('{8'hED, 1'b0, 1'b1});
        fork
            send_byte(8'hED);
            run_device(1'b1, 0);
        join
        repeat (5) @(negedge CLK);

        // 0x00 with exact inhibit / request-to-send timing.
        exp_q.push_back('{8'h00, 1'b0, 1'b1});
        fork
            begin
                send_byte(8'h00);
                n_inh = 0;
                while (ps2clk_oe === 1'b1 && ps2data_oe === 1'b0 && n_inh < INH + 50) begin
                    n_inh++;
                    @(negedge CLK);
                end
                n_rts = 0;
                while (ps2clk_oe === 1'b1 && ps2data_oe === 1'b1 && n_rts < 10) begin
                    n_rts++;
                    @(negedge CLK);
                end
                check("inhibit_cycles", 32'(n_inh), 32'(INH));
                check("rts_cycles", 32'(n_rts), 32'(1));
            end
            run_device(1'b1, 0);
        join
        repeat (5) @(negedge CLK);

        // Device leaves data high on the ACK clock: NACK.
        d = 8'($urandom);
        exp_q.push_back('{d, 1'b1, 1'b1});
        fork
            send_byte(d);
            run_device(1'b0, 0);
        join
        repeat (5) @(negedge CLK);

        // Silent device: timeout measured from SEND entry.
        d = 8'($urandom);
        exp_q.push_back('{d, 1'b1, 1'b0});
        send_byte(d);
        n = 0;
        while (ps2clk_oe !== 1'b0 && n < INH + 50) begin
            @(negedge CLK);
            n++;
        end
        check("send_entry_data_oe", 32'(ps2data_oe), 32'(1));
        n = 0;
        while (tx_if.done !== 1'b1 && n < TMO + 100) begin
            @(negedge CLK);
            n++;
        end
        check("timeout_latency", 32'(n), 32'(TMO));
        repeat (5) @(negedge CLK);

        // Request while busy must be dropped.
        exp_q.push_back('{CMD_RESET_TB(), 1'b0, 1'b1});
        fork
            send_byte(8'hFF);
            run_device(1'b1, 0);
            begin
                n = 0;
                while (!(ps2clk_oe === 1'b0 && ps2data_oe === 1'b1) && n < 5000) begin
                    @(negedge CLK);
                    n++;
                end
                repeat (30) @(negedge CLK);
                check("ready_while_busy", 32'(tx_if.tx_ready), 32'(0));
                check("busy_in_send", 32'(tx_if.busy), 32'(1));
                tx_if.tx_data  = 8'h55;
                tx_if.tx_valid = 1'b1;
                @(negedge CLK);
                tx_if.tx_valid = 1'b0;
            end
        join
        repeat (20) @(negedge CLK);

        // Reset after fall 5: lines released, no done pulse.
        fork
            send_byte(8'($urandom));
            run_device(1'b1, 5);
        join
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_oe", {30'd0, ps2clk_oe, ps2data_oe}, 32'(0));
        check("midrst_ready", 32'(tx_if.tx_ready), 32'(1));
        check("midrst_busy", 32'(tx_if.busy), 32'(0));
        check("midrst_done", 32'(tx_if.done), 32'(0));
        RST = 1'b0;
        repeat (5) @(negedge CLK);
        exp_q.push_back('{8'hF4, 1'b0, 1'b1});
        fork
            send_byte(8'hF4);
            run_device(1'b1, 0);
        join
        repeat (5) @(negedge CLK);

        // Randomised commands with random ACK/NACK.
        for (int t = 0; t < 6; t++) begin
            d   = 8'($urandom);
            ack = 1'($urandom_range(1, 0));
            exp_q.push_back('{d, ~ack, 1'b1});
            fork
                send_byte(d);
                run_device(ack, 0);
            join
            repeat (5) @(negedge CLK);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        repeat (5) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic [7:0] CMD_RESET_TB();
        return 8'hFF;
    endfunction

endmodule
